// File: rtl/tone_arbiter_pkg.sv
// Shared types and constants for the tone arbiter.
// State encoding and the silence step value.
package tone_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } tone_state_e;

  localparam int fstep_silence_c = 0;

endpackage

// File: rtl/prio_encoder.sv
// Fixed-priority one-hot picker, bit 0 wins.
// Ports: req in, gnt one-hot out, any = some bit of req set.
module prio_encoder #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] req,
  output logic [width_p-1:0] gnt,
  output logic               any
);

  // Isolate the lowest set bit.
  assign gnt = req & (~req + width_p'(1));
  assign any = |req;

endmodule

// File: rtl/tone_arbiter.sv
// Shares one tone generator between prioritized requesters.
// Ports: clk_i, reset_i (async low), tick_i, req_* handshake,
// fstep_o/active_o/grant_o registered, done_o/preempt_o pulses.
module tone_arbiter
  import tone_arbiter_pkg::*;
#(
  parameter int num_req_p     = 4,
  parameter int fstep_width_p = 32,
  parameter int dur_width_p   = 8,
  parameter int gap_ticks_p   = 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    tick_i,
  input  logic [num_req_p-1:0]                    req_valid_i,
  output logic [num_req_p-1:0]                    req_ready_o,
  input  logic [num_req_p-1:0][fstep_width_p-1:0] req_fstep_i,
  input  logic [num_req_p-1:0][dur_width_p-1:0]   req_dur_i,
  output logic [fstep_width_p-1:0]                fstep_o,
  output logic                                    active_o,
  output logic [num_req_p-1:0]                    grant_o,
  output logic                                    done_o,
  output logic                                    preempt_o
);

  localparam int gap_w =
    (gap_ticks_p > 0) ? $clog2(gap_ticks_p + 1) : 1;
  localparam logic [gap_w-1:0] gap_load_c =
    gap_w'(gap_ticks_p);
  localparam logic [fstep_width_p-1:0] silence_c =
    fstep_width_p'(fstep_silence_c);

  tone_state_e state, state_n;

  logic [dur_width_p-1:0]   cnt, cnt_n;
  logic [gap_w-1:0]         gap_cnt, gap_cnt_n;
  logic [fstep_width_p-1:0] fstep_n;
  logic [num_req_p-1:0]     grant_n;
  logic                     active_n;
  logic                     done_n;
  logic                     preempt_n;

  logic [num_req_p-1:0]     mask;
  logic [num_req_p-1:0]     pick;
  logic                     any;
  logic [fstep_width_p-1:0] win_fstep;
  logic [dur_width_p-1:0]   win_dur;
  logic [dur_width_p-1:0]   raw_dur;

  // While playing, grant_o is one-hot, so grant-1 marks
  // exactly the strictly higher-priority requesters.
  always_comb begin
    mask = '0;
    unique case (state)
      IDLE:    mask = '1;
      PLAY:    mask = grant_o - num_req_p'(1);
      default: mask = '0;
    endcase
  end

  prio_encoder #(
    .width_p(num_req_p)
  ) u_pick (
    .req(req_valid_i & mask),
    .gnt(pick),
    .any(any)
  );

  assign req_ready_o = pick;

  always_comb begin
    win_fstep = '0;
    raw_dur   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (pick[i]) begin
        win_fstep = win_fstep | req_fstep_i[i];
        raw_dur   = raw_dur | req_dur_i[i];
      end
    end
  end

  // Zero duration plays as one tick, so cnt never wraps.
  assign win_dur = (raw_dur == '0) ? dur_width_p'(1) : raw_dur;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    gap_cnt_n = gap_cnt;
    fstep_n   = fstep_o;
    grant_n   = grant_o;
    active_n  = active_o;
    done_n    = 1'b0;
    preempt_n = 1'b0;
    // An accept takes precedence over a coincident tick.
    if (any) begin
      state_n   = PLAY;
      cnt_n     = win_dur;
      fstep_n   = win_fstep;
      grant_n   = pick;
      active_n  = 1'b1;
      preempt_n = (state == PLAY);
    end else if (tick_i) begin
      unique case (state)
        PLAY: begin
          cnt_n = cnt - dur_width_p'(1);
          if (cnt == dur_width_p'(1)) begin
            done_n   = 1'b1;
            fstep_n  = silence_c;
            grant_n  = '0;
            active_n = 1'b0;
            if (gap_ticks_p == 0) begin
              state_n = IDLE;
            end else begin
              state_n   = GAP;
              gap_cnt_n = gap_load_c;
            end
          end
        end
        GAP: begin
          gap_cnt_n = gap_cnt - gap_w'(1);
          if (gap_cnt <= gap_w'(1)) begin
            state_n = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      cnt       <= '0;
      gap_cnt   <= '0;
      fstep_o   <= silence_c;
      grant_o   <= '0;
      active_o  <= 1'b0;
      done_o    <= 1'b0;
      preempt_o <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gap_cnt   <= gap_cnt_n;
      fstep_o   <= fstep_n;
      grant_o   <= grant_n;
      active_o  <= active_n;
      done_o    <= done_n;
      preempt_o <= preempt_n;
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// Testbench for tone_arbiter: directed vector table,
// reset-mid-note sequence, and randomized model checking.
module tb_tone_arbiter;

  localparam int N   = 4;
  localparam int FW  = 32;
  localparam int DW  = 8;
  localparam int GAP = 1;

  localparam logic [31:0] F0 = 32'h0004_0000;
  localparam logic [31:0] F1 = 32'h0002_0000;
  localparam logic [31:0] F2 = 32'h0001_0000;
  localparam logic [31:0] F3 = 32'h0000_8000;

  logic clk = 1'b0;
  logic reset_i;
  logic tick_i;
  logic [N-1:0] req_valid_i;
  logic [N-1:0] req_ready_o;
  logic [N-1:0][FW-1:0] req_fstep_i;
  logic [N-1:0][DW-1:0] req_dur_i;
  logic [FW-1:0] fstep_o;
  logic active_o;
  logic [N-1:0] grant_o;
  logic done_o;
  logic preempt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_arbiter #(
    .num_req_p(N),
    .fstep_width_p(FW),
    .dur_width_p(DW),
    .gap_ticks_p(GAP)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .tick_i(tick_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_fstep_i(req_fstep_i),
    .req_dur_i(req_dur_i),
    .fstep_o(fstep_o),
    .active_o(active_o),
    .grant_o(grant_o),
    .done_o(done_o),
    .preempt_o(preempt_o)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  dur;
    logic        tick;
    logic [3:0]  ready;
    logic [31:0] fstep;
    logic [3:0]  grant;
    logic        active;
    logic        done;
    logic        pre;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(
    logic [3:0] v, logic [7:0] d, logic t,
    logic [3:0] r, logic [31:0] f, logic [3:0] g,
    logic a, logic dn, logic p);
    vec_t x;
    x.valid = v; x.dur = d; x.tick = t;
    x.ready = r; x.fstep = f; x.grant = g;
    x.active = a; x.done = dn; x.pre = p;
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference model state (plain integers).
  int owner;
  int left;
  int gap_left;
  logic [31:0] m_fstep;

  task automatic mstep(logic [3:0] valid, logic tick);
    int lv;
    logic [3:0] er;
    logic m_done;
    logic m_pre;
    req_valid_i = valid;
    tick_i = tick;
    for (int i = 0; i < N; i++) begin
      req_fstep_i[i] = $urandom;
      req_dur_i[i] = 8'($urandom_range(0, 5));
    end
    lv = -1;
    for (int i = N - 1; i >= 0; i--)
      if (valid[i]) lv = i;
    er = '0;
    if (gap_left == 0 && lv >= 0 &&
        (owner < 0 || lv < owner))
      er[lv] = 1'b1;
    @(negedge clk);
    chk("rnd_ready", req_ready_o, er);
    m_done = 1'b0;
    m_pre = 1'b0;
    if (er != 0) begin
      m_pre = (owner >= 0);
      owner = lv;
      left = (req_dur_i[lv] == 0) ? 1 : int'(req_dur_i[lv]);
      m_fstep = req_fstep_i[lv];
    end else if (tick) begin
      if (owner >= 0) begin
        left--;
        if (left == 0) begin
          m_done = 1'b1;
          owner = -1;
          gap_left = GAP;
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end
    end
    @(posedge clk);
    #1;
    chk("rnd_fstep", fstep_o, (owner >= 0) ? m_fstep : 32'h0);
    chk("rnd_grant", grant_o,
        (owner >= 0) ? (64'h1 << owner) : 64'h0);
    chk("rnd_active", active_o, owner >= 0);
    chk("rnd_done", done_o, m_done);
    chk("rnd_preempt", preempt_o, m_pre);
  endtask

  initial begin
    tbl[0]  = mk(4'b0100, 3, 0, 4'b0100, F2, 4'b0100, 1, 0, 0);
    tbl[1]  = mk(4'b0000, 3, 1, 4'b0000, F2, 4'b0100, 1, 0, 0);
    tbl[2]  = mk(4'b0000, 3, 0, 4'b0000, F2, 4'b0100, 1, 0, 0);
    tbl[3]  = mk(4'b0000, 3, 1, 4'b0000, F2, 4'b0100, 1, 0, 0);
    tbl[4]  = mk(4'b0000, 3, 1, 4'b0000, 0, 4'b0000, 0, 1, 0);
    tbl[5]  = mk(4'b0010, 3, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[6]  = mk(4'b0010, 3, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[7]  = mk(4'b1010, 0, 1, 4'b0010, F1, 4'b0010, 1, 0, 0);
    tbl[8]  = mk(4'b1000, 0, 0, 4'b0000, F1, 4'b0010, 1, 0, 0);
    tbl[9]  = mk(4'b1000, 0, 1, 4'b0000, 0, 4'b0000, 0, 1, 0);
    tbl[10] = mk(4'b1000, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[11] = mk(4'b1000, 2, 0, 4'b1000, F3, 4'b1000, 1, 0, 0);
    tbl[12] = mk(4'b0000, 2, 1, 4'b0000, F3, 4'b1000, 1, 0, 0);
    tbl[13] = mk(4'b0000, 2, 1, 4'b0000, 0, 4'b0000, 0, 1, 0);
    tbl[14] = mk(4'b0000, 2, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[15] = mk(4'b0100, 4, 0, 4'b0100, F2, 4'b0100, 1, 0, 0);
    tbl[16] = mk(4'b0000, 4, 1, 4'b0000, F2, 4'b0100, 1, 0, 0);
    tbl[17] = mk(4'b0100, 4, 1, 4'b0000, F2, 4'b0100, 1, 0, 0);
    tbl[18] = mk(4'b0101, 2, 1, 4'b0001, F0, 4'b0001, 1, 0, 1);
    tbl[19] = mk(4'b0000, 2, 1, 4'b0000, F0, 4'b0001, 1, 0, 0);
    tbl[20] = mk(4'b0000, 2, 1, 4'b0000, 0, 4'b0000, 0, 1, 0);
    tbl[21] = mk(4'b0000, 2, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[22] = mk(4'b0001, 2, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[23] = mk(4'b0001, 2, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[24] = mk(4'b0001, 1, 0, 4'b0001, F0, 4'b0001, 1, 0, 0);
    tbl[25] = mk(4'b0000, 1, 1, 4'b0000, 0, 4'b0000, 0, 1, 0);
    tbl[26] = mk(4'b0000, 1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);

    reset_i = 1'b0;
    tick_i = 1'b0;
    req_valid_i = '0;
    req_fstep_i[0] = F0;
    req_fstep_i[1] = F1;
    req_fstep_i[2] = F2;
    req_fstep_i[3] = F3;
    for (int i = 0; i < N; i++) req_dur_i[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fstep", fstep_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_active", active_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_preempt", preempt_o, 0);
    reset_i = 1'b1;

    for (int k = 0; k < 27; k++) begin
      req_valid_i = tbl[k].valid;
      tick_i = tbl[k].tick;
      for (int i = 0; i < N; i++) req_dur_i[i] = tbl[k].dur;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", k), req_ready_o, tbl[k].ready);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_fstep", k), fstep_o, tbl[k].fstep);
      chk($sformatf("tbl%0d_grant", k), grant_o, tbl[k].grant);
      chk($sformatf("tbl%0d_active", k), active_o, tbl[k].active);
      chk($sformatf("tbl%0d_done", k), done_o, tbl[k].done);
      chk($sformatf("tbl%0d_preempt", k), preempt_o, tbl[k].pre);
    end

    // Reset in the middle of a note.
    req_valid_i = 4'b0010;
    tick_i = 1'b0;
    for (int i = 0; i < N; i++) req_dur_i[i] = 8'd5;
    @(posedge clk);
    #1;
    chk("mid_grant", grant_o, 4'b0010);
    chk("mid_active", active_o, 1);
    req_valid_i = '0;
    #3;
    reset_i = 1'b0;
    #1;
    chk("arst_fstep", fstep_o, 0);
    chk("arst_active", active_o, 0);
    chk("arst_grant", grant_o, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b1;

    owner = -1;
    left = 0;
    gap_left = 0;
    m_fstep = '0;
    mstep(4'b0100, 1'b0);
    chk("post_rst_grant", grant_o, 4'b0100);
    for (int c = 0; c < 600; c++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      mstep(v, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

Shares the game's single tone generator between several sound requesters (background music, sound effects, UI beeps). Each requester offers a frequency step and a duration in ticks; the arbiter grants by fixed priority, drives the winning `fstep_o` to the NCO, times the note against the tick pulse from the game state machine, and inserts a silent gap between notes. Higher-priority requests preempt a playing lower-priority note.

## Interface
- `num_req_p`, default 4: number of requesters; index 0 has the highest priority.
- `fstep_width_p`, default 32: width of the frequency step.
- `dur_width_p`, default 8: width of the duration field, in ticks.
- `gap_ticks_p`, default 1: silent ticks inserted after every naturally completed note; 0 means no gap.
- `clk_i` in 1: single clock.
- `reset_i` in 1: asynchronous, active-low reset.
- `tick_i` in 1: one-cycle timing pulse, for example the game `second` strobe or a faster divider output.
- `req_valid_i` in `num_req_p`: a note is offered, one bit per requester.
- `req_ready_o` out `num_req_p`: one-hot, combinational; the note is accepted when valid and ready are both high.
- `req_fstep_i` in `num_req_p` x `fstep_width_p`: frequency step per requester.
- `req_dur_i` in `num_req_p` x `dur_width_p`: note length in ticks; 0 is treated as 1.
- `fstep_o` out `fstep_width_p`: registered; goes to the tone generator; 0 means silence.
- `active_o` out 1: registered; high in PLAY.
- `grant_o` out `num_req_p`: registered, one-hot; the owner of the current note; 0 outside PLAY.
- `done_o` out 1: one-cycle pulse when a note completes naturally.
- `preempt_o` out 1: one-cycle pulse when a note is cut off by preemption.

## Operation
- Reset (`reset_i` low):
  - State is IDLE.
  - `fstep_o`, `grant_o`, `active_o`, `done_o`, `preempt_o` are all 0.
  - The duration counter is 0.
- `req_ready_o` rules:
  - In IDLE: set for the lowest-index valid requester.
  - In PLAY: set only if the lowest-index valid requester has an index strictly below the current owner's.
  - In GAP: all 0.
- IDLE -> PLAY on an accept:
  - Load the counter with `max(dur,1)`.
  - Load `fstep_o` and `grant_o` from the winner.
  - Set `active_o`.
- PLAY, on `tick_i`: decrement the counter. If the counter was 1:
  - Pulse `done_o`.
  - Set `fstep_o` and `grant_o` to 0.
  - Go to GAP, or to IDLE when `gap_ticks_p`=0.
- PLAY, on a preempting accept:
  - Reload the counter, `fstep_o` and `grant_o` from the new owner.
  - Pulse `preempt_o`.
  - Stay in PLAY. No gap is inserted and there is no `done_o` for the old note.
- Accept and `tick_i` in the same cycle: the accept wins; the tick is not applied to the new note.
- GAP: count `gap_ticks_p` ticks with `fstep_o`=0, then go to IDLE. Requests are held off and are not lost; requesters keep valid asserted.
- A requester may drop valid before it is accepted. Once accepted, its note plays independently of that requester's valid.
- Duration arithmetic is unsigned `dur_width_p`. The counter never wraps, because a load of 0 is forced to 1.

## Timing
- Accept in cycle N: `fstep_o`, `grant_o` and `active_o` are valid from N+1, so latency is 1 cycle.
- A note of duration D ends on the D-th tick seen after acceptance. `done_o` is high in the cycle after that tick, and `fstep_o` is 0 from the same cycle.
- The earliest next accept is the cycle after the final gap tick.
- Reset asserted mid-note: outputs clear immediately (asynchronous reset). On release, the block resumes in IDLE. No `done_o` or `preempt_o` is issued for the aborted note.

## Structure
- Package `tone_arbiter_pkg` holds:
  - the state enum `tone_state_e` {IDLE, PLAY, GAP};
  - the constant `fstep_silence_c` = 0.
- Sub-module `prio_encoder`: parameterized fixed-priority one-hot picker over `num_req_p` bits, with an any-valid output. It is instantiated once; the preemption mask is applied to its input.
- Top level holds the state register, the duration and gap counters, and the output registers.

## Test plan
- Single note:
  - Stimulus: requester 2 offers fstep `32'h0001_0000`, dur 3, `gap_ticks_p`=1.
  - Required: ready[2] is high that cycle; next cycle `fstep_o`=`32'h0001_0000` and `grant_o`=`4'b0100`.
  - Required: `done_o` pulses after the 3rd tick; silence lasts for 1 tick, then IDLE.
- Priority:
  - Stimulus: requesters 1 and 3 are both valid in IDLE.
  - Required: only ready[1] is high; `grant_o`=`4'b0010`; requester 3 is accepted only after requester 1's note and gap.
- Preemption:
  - Stimulus: requester 0 becomes valid while requester 2 is in PLAY with 2 ticks left.
  - Required: `preempt_o` pulses, `grant_o`=`4'b0001`, `fstep_o` switches the next cycle; no `done_o` for requester 2.
- No preemption by equal or lower priority:
  - Stimulus: requester 3 is valid while requester 1 is playing.
  - Required: ready[3] stays 0 until IDLE.
- Zero duration, and tick coincident with accept:
  - Stimulus: dur 0 with `tick_i` high in the accept cycle.
  - Required: the note lasts exactly 1 further tick, then `done_o` pulses.
- Reset mid-note:
  - Stimulus: drive `reset_i` low during PLAY.
  - Required: `fstep_o`=0, `active_o`=0 and `grant_o`=0 immediately; after release, a new request is accepted normally.
